queue_scheduler: RTL and testbench
==================================

QUEUE_SCHEDULER -- requirements
Module: queue_scheduler

Interface
REQ-001 The block SHALL have parameter M, default 8, meaning queue depth in entries (power of two, >= 2).
REQ-002 The block SHALL have parameter N, default 4, meaning data width in bits.
REQ-003 The block SHALL have port CLK100MHZ  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req0 / req1  input  1 each  producer enqueue requests, level, held until granted.
REQ-006 The block SHALL have port data0 / data1  input  N each  producer enqueue data, stable while the matching req is high.
REQ-007 The block SHALL have port deq_req  input  1  consumer dequeue request, level, held until granted.
REQ-008 The block SHALL have port gnt0 / gnt1 / deq_gnt  output  1 each  one-cycle grant pulses.
REQ-009 The block SHALL have port en_in  output  1  queue enqueue strobe.
REQ-010 The block SHALL have port en_out  output  1  queue dequeue strobe.
REQ-011 The block SHALL have port in  output  N  queue enqueue data.
REQ-012 The block SHALL have port count  output  $clog2(M)+1  queue occupancy.
REQ-013 The block SHALL have port full / empty  output  1 each  count==M / count==0.

Function
REQ-014 The block SHALL implement FSM states IDLE and ISSUE; IDLE->ISSUE when any eligible request exists at the edge, ISSUE->IDLE unconditionally.
REQ-015 The block SHALL treat producer k as eligible iff reqk=1 and full=0, and the consumer as eligible iff deq_req=1 and empty=0.
REQ-016 The block SHALL sample requests only in IDLE; a request dropped before the IDLE edge SHALL receive no grant.
REQ-017 The block SHALL register all outputs: in ISSUE exactly one of {gnt0, gnt1, deq_gnt} SHALL be 1, with en_in=gnt0|gnt1 and en_out=deq_gnt; all are 0 in IDLE.
REQ-018 The block SHALL register in from the winning producer's data at the IDLE->ISSUE edge and hold it through ISSUE.
REQ-019 The block SHALL deliver one-cycle latency: request sampled at edge k, strobe high between edges k and k+1; maximum throughput one operation per two cycles.
REQ-020 The block SHALL choose between enqueue and dequeue, when both are eligible, by last_op: serve the type not served last.
REQ-021 The block SHALL update last_op on every ISSUE entry.
REQ-022 The block SHALL update count at the ISSUE->IDLE edge: +1 after an enqueue, -1 after a dequeue, never wrapping.
REQ-023 The block SHALL update full/empty combinationally from count.
REQ-024 The block SHALL never issue an enqueue when count==M nor a dequeue when count==0.

Reset
REQ-025 The block SHALL, while reset=0 and independent of the clock, force state=IDLE, all grants/strobes=0, in=0, count=0, full=0, empty=1, last_op=dequeue (enqueue preferred first), rr_ptr=producer 0.
REQ-026 The block SHALL abandon any in-progress operation when reset asserts during ISSUE, without updating count.
REQ-027 The block SHALL begin arbitration at the first rising edge after reset deasserts.

Configuration
REQ-028 The block SHALL, with ROUND_ROBIN_EN defined, arbitrate producers round-robin: when both are eligible, grant the one rr_ptr indicates.
REQ-029 The block SHALL, with ROUND_ROBIN_EN defined, set rr_ptr to the other producer after any producer grant.
REQ-030 The block SHALL, without ROUND_ROBIN_EN, use fixed priority with req0 always over req1, and SHALL contain no rr_ptr register.

Verification
REQ-031 The bench SHALL cover: reset, then req0=1, data0=4'hA -> next cycle gnt0=en_in=1, in=4'hA; following cycle all low; count=1.
REQ-032 The bench SHALL cover: fill with 8 enqueues -> count=8, full=1; req1 held -> no gnt1 until a dequeue completes, then gnt1 issues.
REQ-033 The bench SHALL cover: empty queue, deq_req=1 -> no deq_gnt, empty stays 1; then one enqueue -> deq_gnt on the next arbitration.
REQ-034 The bench SHALL cover: count=3, req0 and deq_req held -> grants alternate enqueue/dequeue, starting opposite last_op; count oscillates 3/4.
REQ-035 The bench SHALL cover: req0 and req1 held, count=0 -> ROUND_ROBIN_EN: gnt0, gnt1, gnt0, gnt1; without it gnt0 until full=1.
REQ-036 The bench SHALL cover: reset asserted mid-ISSUE with count=5 -> en_in/gnt drop immediately, count=0, empty=1.

Source files
------------

// File: rtl/queue_scheduler_if.sv
// Handshake bundle between two producers, one consumer and the queue scheduler.
// The scheduler side uses the slave modport; the requesters use master.
interface queue_scheduler_if #(
    parameter int M = 8,
    parameter int N = 4
);
    localparam int CW = $clog2(M) + 1;

    logic          req0;
    logic          req1;
    logic [N-1:0]  data0;
    logic [N-1:0]  data1;
    logic          deq_req;
    logic          gnt0;
    logic          gnt1;
    logic          deq_gnt;
    logic          en_in;
    logic          en_out;
    logic [N-1:0]  in;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        output req0, req1, data0, data1, deq_req,
        input  gnt0, gnt1, deq_gnt, en_in, en_out, in, count, full, empty
    );

    modport slave (
        input  req0, req1, data0, data1, deq_req,
        output gnt0, gnt1, deq_gnt, en_in, en_out, in, count, full, empty
    );
endinterface

// File: rtl/queue_scheduler.sv
// Queue scheduler: arbitrates two enqueue producers and one dequeue consumer
// onto a single queue of depth M, one operation per IDLE/ISSUE pair.
// Enqueue and dequeue alternate when both are eligible (last_op decides).
// Optional macro ROUND_ROBIN_EN: producers are served round-robin via rr_ptr;
// without it producer 0 always beats producer 1 and no rr_ptr exists.
module queue_scheduler #(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic               CLK100MHZ,
    input  logic               reset,
    queue_scheduler_if.slave   bus
);
    localparam int CW = $clog2(M) + 1;

    typedef enum logic {IDLE, ISSUE} state_t;
    typedef enum logic {OP_ENQ, OP_DEQ} op_t;

    state_t        state;
    state_t        state_nxt;
    op_t           last_op;
    op_t           last_op_nxt;

    logic          gnt0_r;
    logic          gnt1_r;
    logic          deq_gnt_r;
    logic          gnt0_nxt;
    logic          gnt1_nxt;
    logic          deq_gnt_nxt;
    logic [N-1:0]  in_r;
    logic [N-1:0]  in_nxt;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt;

    logic          full_w;
    logic          empty_w;
    logic          elig0;
    logic          elig1;
    logic          enq_elig;
    logic          deq_elig;
    logic          pick1;
    logic          do_enq;

`ifdef ROUND_ROBIN_EN
    logic          rr_ptr;
    logic          rr_ptr_nxt;
`endif

    assign full_w   = (count_r == CW'(M));
    assign empty_w  = (count_r == '0);

    // Eligibility is gated by occupancy so a full/empty queue can never be overrun.
    assign elig0    = bus.req0 & ~full_w;
    assign elig1    = bus.req1 & ~full_w;
    assign enq_elig = elig0 | elig1;
    assign deq_elig = bus.deq_req & ~empty_w;

    // Producer selection: high means producer 1 wins the enqueue slot.
    always_comb begin
        pick1 = 1'b0;
`ifdef ROUND_ROBIN_EN
        pick1 = elig1 & (~elig0 | rr_ptr);
`else
        pick1 = elig1 & ~elig0;
`endif
    end

    // Next-state and next-output logic for the IDLE/ISSUE controller.
    always_comb begin
        state_nxt   = state;
        gnt0_nxt    = 1'b0;
        gnt1_nxt    = 1'b0;
        deq_gnt_nxt = 1'b0;
        in_nxt      = in_r;
        last_op_nxt = last_op;
        count_nxt   = count_r;
        do_enq      = 1'b0;
`ifdef ROUND_ROBIN_EN
        rr_ptr_nxt  = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (enq_elig || deq_elig) begin
                    state_nxt = ISSUE;
                    // On contention serve whichever type was not served last.
                    do_enq = enq_elig & (~deq_elig | (last_op == OP_DEQ));
                    if (do_enq) begin
                        last_op_nxt = OP_ENQ;
                        if (pick1) begin
                            gnt1_nxt = 1'b1;
                            in_nxt   = bus.data1;
`ifdef ROUND_ROBIN_EN
                            rr_ptr_nxt = 1'b0;
`endif
                        end else begin
                            gnt0_nxt = 1'b1;
                            in_nxt   = bus.data0;
`ifdef ROUND_ROBIN_EN
                            rr_ptr_nxt = 1'b1;
`endif
                        end
                    end else begin
                        last_op_nxt = OP_DEQ;
                        deq_gnt_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                state_nxt = IDLE;
                // Occupancy changes only when the issued operation completes.
                if ((gnt0_r || gnt1_r) && !full_w) begin
                    count_nxt = count_r + CW'(1);
                end else if (deq_gnt_r && !empty_w) begin
                    count_nxt = count_r - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered grants, strobes, enqueue data, occupancy and arbitration history.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            deq_gnt_r <= 1'b0;
            in_r      <= '0;
            count_r   <= '0;
            last_op   <= OP_DEQ;
        end else begin
            gnt0_r    <= gnt0_nxt;
            gnt1_r    <= gnt1_nxt;
            deq_gnt_r <= deq_gnt_nxt;
            in_r      <= in_nxt;
            count_r   <= count_nxt;
            last_op   <= last_op_nxt;
        end
    end

`ifdef ROUND_ROBIN_EN
    // Round-robin pointer: points at the producer to favour on the next tie.
    always_ff @(posedge CLK100MHZ or negedge reset) begin
        if (!reset) begin
            rr_ptr <= 1'b0;
        end else begin
            rr_ptr <= rr_ptr_nxt;
        end
    end
`endif

    assign bus.gnt0    = gnt0_r;
    assign bus.gnt1    = gnt1_r;
    assign bus.deq_gnt = deq_gnt_r;
    assign bus.en_in   = gnt0_r | gnt1_r;
    assign bus.en_out  = deq_gnt_r;
    assign bus.in      = in_r;
    assign bus.count   = count_r;
    assign bus.full    = full_w;
    assign bus.empty   = empty_w;
endmodule

// File: tb/tb_queue_scheduler.sv
// Directed bench for queue_scheduler (M=8, N=4): a cycle-by-cycle vector
// table plus hand-written sequences for fill, alternation, arbitration and
// mid-operation reset.
module tb_queue_scheduler;
    localparam int M = 8;
    localparam int N = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    queue_scheduler_if #(.M(M), .N(N)) qif ();

    queue_scheduler #(.M(M), .N(N)) dut (
        .CLK100MHZ (clk),
        .reset     (reset),
        .bus       (qif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r0;
        logic       r1;
        logic [3:0] d0;
        logic [3:0] d1;
        logic       dq;
        logic       g0;
        logic       g1;
        logic       dg;
        logic       ei;
        logic       eo;
        logic [3:0] din;
        logic [3:0] cnt;
        logic       fl;
        logic       em;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(input logic r0, input logic r1, input logic [3:0] d0,
                                input logic [3:0] d1, input logic dq, input logic g0,
                                input logic g1, input logic dg, input logic [3:0] din,
                                input logic [3:0] cnt);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.dq = dq;
        v.g0 = g0; v.g1 = g1; v.dg = dg;
        v.ei = g0 | g1; v.eo = dg;
        v.din = din; v.cnt = cnt;
        v.fl = (cnt == 4'd8); v.em = (cnt == 4'd0);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        qif.req0    = 1'b0;
        qif.req1    = 1'b0;
        qif.data0   = '0;
        qif.data1   = '0;
        qif.deq_req = 1'b0;
        #2;
        chk("rst_gnt0", qif.gnt0, 0);
        chk("rst_gnt1", qif.gnt1, 0);
        chk("rst_deq_gnt", qif.deq_gnt, 0);
        chk("rst_en_in", qif.en_in, 0);
        chk("rst_en_out", qif.en_out, 0);
        chk("rst_in", qif.in, 0);
        chk("rst_count", qif.count, 0);
        chk("rst_full", qif.full, 0);
        chk("rst_empty", qif.empty, 1);
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;

        //            r0 r1 d0    d1    dq g0 g1 dg din   cnt
        vecs[0]  = mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'd0);
        vecs[1]  = mk(1, 0, 4'hA, 4'h0, 0, 1, 0, 0, 4'hA, 4'd0);
        vecs[2]  = mk(0, 0, 4'hA, 4'h0, 0, 0, 0, 0, 4'h0, 4'd1);
        vecs[3]  = mk(0, 0, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0, 4'd1);
        vecs[4]  = mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'd0);
        vecs[5]  = mk(0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 4'd0);
        vecs[6]  = mk(0, 0, 4'h0, 4'h0, 1, 0, 0, 0, 4'h0, 4'd0);
        vecs[7]  = mk(0, 1, 4'h0, 4'h5, 1, 0, 1, 0, 4'h5, 4'd0);
        vecs[8]  = mk(0, 0, 4'h0, 4'h5, 1, 0, 0, 0, 4'h0, 4'd1);
        vecs[9]  = mk(0, 0, 4'h0, 4'h0, 1, 0, 0, 1, 4'h0, 4'd1);
        vecs[10] = mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'd0);
        vecs[11] = mk(1, 1, 4'h3, 4'hC, 0, 1, 0, 0, 4'h3, 4'd0);
        vecs[12] = mk(0, 1, 4'h3, 4'hC, 0, 0, 0, 0, 4'h0, 4'd1);
        vecs[13] = mk(0, 1, 4'h0, 4'hC, 0, 0, 1, 0, 4'hC, 4'd1);
        vecs[14] = mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 4'h0, 4'd2);

        do_reset();

        // Table: single enqueue, dequeue, dequeue on empty, producer priority.
        for (int i = 0; i < 15; i++) begin
            qif.req0    = vecs[i].r0;
            qif.req1    = vecs[i].r1;
            qif.data0   = vecs[i].d0;
            qif.data1   = vecs[i].d1;
            qif.deq_req = vecs[i].dq;
            cyc();
            chk($sformatf("v%0d_gnt0", i), qif.gnt0, vecs[i].g0);
            chk($sformatf("v%0d_gnt1", i), qif.gnt1, vecs[i].g1);
            chk($sformatf("v%0d_deq_gnt", i), qif.deq_gnt, vecs[i].dg);
            chk($sformatf("v%0d_en_in", i), qif.en_in, vecs[i].ei);
            chk($sformatf("v%0d_en_out", i), qif.en_out, vecs[i].eo);
            chk($sformatf("v%0d_count", i), qif.count, vecs[i].cnt);
            chk($sformatf("v%0d_full", i), qif.full, vecs[i].fl);
            chk($sformatf("v%0d_empty", i), qif.empty, vecs[i].em);
            if (vecs[i].ei) chk($sformatf("v%0d_in", i), qif.in, vecs[i].din);
        end

        // Fill to full, producer 1 blocked until a dequeue frees a slot.
        do_reset();
        qif.req0  = 1'b1;
        qif.data0 = 4'h9;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("fill_gnt0", qif.gnt0, 1);
            cyc();
            chk("fill_count", qif.count, i + 1);
        end
        chk("fill_full", qif.full, 1);
        qif.req0  = 1'b0;
        qif.req1  = 1'b1;
        qif.data1 = 4'h7;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("full_no_gnt1", qif.gnt1, 0);
        end
        qif.deq_req = 1'b1;
        cyc();
        chk("full_deq_gnt", qif.deq_gnt, 1);
        chk("full_deq_no_gnt1", qif.gnt1, 0);
        qif.deq_req = 1'b0;
        cyc();
        chk("after_deq_count", qif.count, 7);
        chk("after_deq_full", qif.full, 0);
        chk("after_deq_no_gnt1", qif.gnt1, 0);
        cyc();
        chk("refill_gnt1", qif.gnt1, 1);
        chk("refill_in", qif.in, 4'h7);
        qif.req1 = 1'b0;
        cyc();
        chk("refill_count", qif.count, 8);
        chk("refill_full", qif.full, 1);

        // Alternation at count=3 after a dequeue: enqueue goes first.
        do_reset();
        qif.req0  = 1'b1;
        qif.data0 = 4'h2;
        for (int i = 0; i < 4; i++) begin
            cyc();
            cyc();
        end
        chk("alt_pre_count4", qif.count, 4);
        qif.req0    = 1'b0;
        qif.deq_req = 1'b1;
        cyc();
        chk("alt_pre_deq", qif.deq_gnt, 1);
        qif.deq_req = 1'b0;
        cyc();
        chk("alt_pre_count3", qif.count, 3);
        qif.req0    = 1'b1;
        qif.deq_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("alt_gnt0", qif.gnt0, (k % 2 == 0) ? 1 : 0);
            chk("alt_deq_gnt", qif.deq_gnt, (k % 2 == 1) ? 1 : 0);
            cyc();
            chk("alt_count", qif.count, (k % 2 == 0) ? 4 : 3);
        end
        qif.req0    = 1'b0;
        qif.deq_req = 1'b0;

        // Both producers held from empty until full.
        do_reset();
        qif.req0  = 1'b1;
        qif.req1  = 1'b1;
        qif.data0 = 4'h1;
        qif.data1 = 4'h2;
        for (int k = 0; k < 8; k++) begin
            logic exp0;
`ifdef ROUND_ROBIN_EN
            exp0 = (k % 2 == 0);
`else
            exp0 = 1'b1;
`endif
            cyc();
            chk("arb_gnt0", qif.gnt0, exp0);
            chk("arb_gnt1", qif.gnt1, !exp0);
            chk("arb_in", qif.in, exp0 ? 4'h1 : 4'h2);
            cyc();
        end
        chk("arb_count", qif.count, 8);
        chk("arb_full", qif.full, 1);
        cyc();
        chk("arb_full_no_gnt", qif.en_in, 0);
        qif.req0 = 1'b0;
        qif.req1 = 1'b0;

        // Reset asserted in the middle of an ISSUE cycle with count=5.
        do_reset();
        qif.req0  = 1'b1;
        qif.data0 = 4'h6;
        for (int i = 0; i < 5; i++) begin
            cyc();
            cyc();
        end
        chk("mid_count5", qif.count, 5);
        cyc();
        chk("mid_en_in_before", qif.en_in, 1);
        chk("mid_gnt0_before", qif.gnt0, 1);
        #3;
        reset = 1'b0;
        #1;
        chk("mid_en_in", qif.en_in, 0);
        chk("mid_gnt0", qif.gnt0, 0);
        chk("mid_count", qif.count, 0);
        chk("mid_empty", qif.empty, 1);
        chk("mid_full", qif.full, 0);
        qif.req0 = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        chk("post_rst_count", qif.count, 0);
        chk("post_rst_en_in", qif.en_in, 0);
        chk("post_rst_empty", qif.empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
